// File: rtl/ptp_irq_ctrl_pkg.sv
// Shared constants for the PTP interrupt controller: register map,
// AXI response codes, source indices and the default version word.
package ptp_irq_ctrl_pkg;

    localparam logic [7:0] ADDR_RAW    = 8'h00;
    localparam logic [7:0] ADDR_PEND   = 8'h04;
    localparam logic [7:0] ADDR_ENABLE = 8'h08;
    localparam logic [7:0] ADDR_MODE   = 8'h0C;
    localparam logic [7:0] ADDR_SWSET  = 8'h10;
    localparam logic [7:0] ADDR_ID     = 8'h14;
    localparam logic [7:0] ADDR_END    = 8'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int IRQ_GMAC   = 0;
    localparam int IRQ_PTP    = 1;
    localparam int IRQ_RTC    = 2;
    localparam int IRQ_GPIO   = 3;
    localparam int IRQ_TIMER0 = 4;
    localparam int IRQ_TIMER3 = 7;
    localparam int IRQ_SWD    = 8;
    localparam int IRQ_SWU    = 9;

    localparam logic [31:0] DEF_VERSION = 32'h2018_0601;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/ptp_irq_ctrl_axi_capture.sv
// Per-source capture: optional two-flop synchronizer (IRQ_CTRL_SYNC_EN),
// previous-sample register and edge/level pending logic.
module ptp_irq_capture
    import ptp_irq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_src,
    input  logic [31:0] i_mode,
    input  logic [31:0] i_clr,
    input  logic [31:0] i_set,
    output logic [31:0] o_raw,
    output logic [31:0] o_pend
);

    logic [31:0] w_s;
    logic [31:0] w_rise;
    logic [31:0] r_src_d;
    logic [31:0] r_pend;

`ifdef IRQ_CTRL_SYNC_EN
    logic [31:0] r_sync1;
    logic [31:0] r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_src;
`endif

    assign w_rise = w_s & ~r_src_d;

    // Level bits keep r_pend cleared so a switch to edge mode starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_d <= '0;
            r_pend  <= '0;
        end else begin
            r_src_d <= w_s;
            r_pend  <= i_mode & (w_rise | i_set | (r_pend & ~i_clr));
        end
    end

    assign o_raw  = r_src_d;
    assign o_pend = (i_mode & r_pend) | (~i_mode & w_s);

endmodule

// File: rtl/ptp_irq_ctrl_axi.sv
// PTP/MAC interrupt aggregator with AXI4-Lite register access.
// Define IRQ_CTRL_SYNC_EN to synchronize asynchronous irq_src lines.
module ptp_irq_ctrl_axi
    import ptp_irq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ = 10,
    parameter logic [31:0] VERSION = DEF_VERSION
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_areset,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               irq_out,
    input  logic [7:0]         s_axi_awaddr,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [7:0]         s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready
);

    localparam logic [31:0] IRQ_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << NUM_IRQ) - 32'd1);

    wstate_t     r_wstate;
    rstate_t     r_rstate;
    logic [31:0] r_enable;
    logic [31:0] r_mode;
    logic [31:0] r_rdata;
    logic [1:0]  r_bresp;
    logic [1:0]  r_rresp;
    logic        r_bvalid;
    logic        r_rvalid;
    logic        r_irq;

    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [7:0]  w_waddr;
    logic [7:0]  w_raddr;
    logic [31:0] w_src;
    logic [31:0] w_wmask;
    logic [31:0] w_wbits;
    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_raw;
    logic [31:0] w_pend;
    logic [31:0] w_rword;

    assign w_waddr   = s_axi_awaddr & 8'hFC;
    assign w_raddr   = s_axi_araddr & 8'hFC;
    assign w_src     = 32'(irq_src);
    assign w_wr_fire = (r_wstate == W_IDLE) && s_axi_awvalid
                    && s_axi_wvalid && !s_axi_areset;
    assign w_rd_fire = (r_rstate == R_IDLE) && s_axi_arvalid && !s_axi_areset;

    assign s_axi_awready = w_wr_fire;
    assign s_axi_wready  = w_wr_fire;
    assign s_axi_arready = w_rd_fire;

    assign w_wmask = strb_mask(s_axi_wstrb) & IRQ_MASK;
    assign w_wbits = s_axi_wdata & w_wmask;
    assign w_clr   = (w_wr_fire && w_waddr == ADDR_PEND)  ? w_wbits : '0;
    assign w_set   = (w_wr_fire && w_waddr == ADDR_SWSET) ? w_wbits : '0;

    ptp_irq_capture u_capture (
        .clk    (s_axi_aclk),
        .rst    (s_axi_areset),
        .i_src  (w_src),
        .i_mode (r_mode),
        .i_clr  (w_clr),
        .i_set  (w_set),
        .o_raw  (w_raw),
        .o_pend (w_pend)
    );

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_enable <= '0;
            r_mode   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                        r_bresp  <= (w_waddr < ADDR_END) ? RESP_OKAY : RESP_SLVERR;
                        if (w_waddr == ADDR_ENABLE)
                            r_enable <= (r_enable & ~w_wmask) | w_wbits;
                        if (w_waddr == ADDR_MODE)
                            r_mode <= (r_mode & ~w_wmask) | w_wbits;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_wstate <= W_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rword = '0;
        case (w_raddr)
            ADDR_RAW:    w_rword = w_raw;
            ADDR_PEND:   w_rword = w_pend;
            ADDR_ENABLE: w_rword = r_enable;
            ADDR_MODE:   w_rword = r_mode;
            ADDR_ID:     w_rword = VERSION;
            default:     w_rword = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_fire) begin
                        r_rstate <= R_DATA;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_rword;
                        r_rresp  <= (w_raddr < ADDR_END) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_rstate <= R_IDLE;
                        r_rvalid <= 1'b0;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) r_irq <= 1'b0;
        else              r_irq <= |(w_pend & r_enable);
    end

    assign irq_out      = r_irq;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;

endmodule

// File: tb/tb_ptp_irq_ctrl_axi.sv
// Randomized scoreboard bench for ptp_irq_ctrl_axi against a
// behavioural register/pending model.
module tb_ptp_irq_ctrl_axi;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_src = '0;
    logic         irq_out;
    logic [7:0]   awaddr = '0, araddr = '0;
    logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ptp_irq_ctrl_axi #(.NUM_IRQ(N)) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .irq_src       (irq_src),
        .irq_out       (irq_out),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    // Reference model state
    logic [N-1:0] m_en, m_mode, m_pend, m_prev;
    logic         m_irq, m_wbusy, m_rbusy;
    logic [31:0]  rq_data[$];
    logic [1:0]   rq_resp[$];
    logic [1:0]   bq[$];

    function automatic logic [N-1:0] pend_view(input logic [N-1:0] src);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            v[i] = m_mode[i] ? m_pend[i] : src[i];
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic [N-1:0] src);
        logic [7:0] w;
        w = a & 8'hFC;
        case (w)
            8'h00:   return 32'(m_prev);
            8'h04:   return 32'(pend_view(src));
            8'h08:   return 32'(m_en);
            8'h0C:   return 32'(m_mode);
            8'h14:   return 32'h2018_0601;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [N-1:0] src, old_mode, clr, set, keep, bits;
        logic [31:0]  mk;
        logic [7:0]   a;
        logic         nxt_irq;
        if (rst) begin
            m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0;
            m_irq = 0; m_wbusy = 0; m_rbusy = 0;
            rq_data.delete(); rq_resp.delete(); bq.delete();
        end else begin
            src      = irq_src;
            old_mode = m_mode;
            nxt_irq  = |(pend_view(src) & m_en);
            if (m_rbusy) begin
                if (rready) m_rbusy = 0;
            end else if (arvalid) begin
                rq_data.push_back(m_read(araddr, src));
                rq_resp.push_back(((araddr & 8'hFC) >= 8'h18) ? 2'b10 : 2'b00);
                m_rbusy = 1;
            end
            clr = '0;
            set = '0;
            if (m_wbusy) begin
                if (bready) m_wbusy = 0;
            end else if (awvalid && wvalid) begin
                mk = '0;
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mk[8*b +: 8] = 8'hFF;
                keep = mk[N-1:0];
                bits = wdata[N-1:0] & keep;
                a = awaddr & 8'hFC;
                bq.push_back((a >= 8'h18) ? 2'b10 : 2'b00);
                case (a)
                    8'h04: clr = bits;
                    8'h08: m_en = (m_en & ~keep) | bits;
                    8'h0C: m_mode = (m_mode & ~keep) | bits;
                    8'h10: set = bits;
                    default: ;
                endcase
                m_wbusy = 1;
            end
            for (int i = 0; i < N; i++) begin
                if (old_mode[i])
                    m_pend[i] = (src[i] & ~m_prev[i]) | set[i] | (m_pend[i] & ~clr[i]);
                else
                    m_pend[i] = 1'b0;
            end
            m_prev = src;
            m_irq  = nxt_irq;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [31:0] ed;
        logic [1:0]  er;
        #1;
        if (!rst) begin
            n_cmp++;
            if (irq_out !== m_irq) begin
                n_err++;
                $display("FAIL irq_out @%0t: got %b expected %b", $time, irq_out, m_irq);
            end
            if (bvalid && bready) begin
                n_cmp++;
                if (bq.size() == 0) begin
                    n_err++;
                    $display("FAIL bresp_unexpected @%0t: got bvalid with bresp %b", $time, bresp);
                end else begin
                    er = bq.pop_front();
                    if (bresp !== er) begin
                        n_err++;
                        $display("FAIL bresp @%0t: got %b expected %b", $time, bresp, er);
                    end
                end
            end
            if (rvalid && rready) begin
                n_cmp++;
                if (rq_data.size() == 0) begin
                    n_err++;
                    $display("FAIL rdata_unexpected @%0t: got rvalid with %h", $time, rdata);
                end else begin
                    ed = rq_data.pop_front();
                    er = rq_resp.pop_front();
                    if (rdata !== ed || rresp !== er) begin
                        n_err++;
                        $display("FAIL rdata @%0t: got %h/%b expected %h/%b",
                                 $time, rdata, rresp, ed, er);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input int hold,
                      input logic wsrc_en, input logic [N-1:0] wsrc);
        int t;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1;
        for (int i = 0; i < lead; i++) begin
            #1;
            n_cmp++;
            if (awready !== 1'b0) begin
                n_err++;
                $display("FAIL aw_alone: awready=%b expected 0", awready);
            end
            @(negedge clk);
        end
        wvalid = 1;
        if (wsrc_en) irq_src = wsrc;
        t = 0;
        #1;
        while (awready !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_err++;
            $display("FAIL aw_w_accept: awready=%b wready=%b expected 1 1", awready, wready);
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < hold; i++) begin
            #1;
            n_cmp++;
            if (bvalid !== 1'b1) begin
                n_err++;
                $display("FAIL bvalid_hold: bvalid=%b expected 1", bvalid);
            end
            @(negedge clk);
        end
        bready = 1;
        t = 0;
        #1;
        while (bvalid !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        if (bvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL bvalid_timeout: bvalid=%b expected 1", bvalid);
        end
        @(negedge clk);
        bready = 0;
    endtask

    task automatic wrs(input logic [7:0] a, input logic [31:0] d);
        wr(a, d, 4'hF, 0, 0, 1'b0, '0);
    endtask

    task automatic rd(input logic [7:0] a, input int hold);
        int t;
        @(negedge clk);
        araddr = a; arvalid = 1;
        t = 0;
        #1;
        while (arready !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_accept: arready=%b expected 1", arready);
        end
        @(negedge clk);
        arvalid = 0;
        for (int i = 0; i < hold; i++) @(negedge clk);
        rready = 1;
        t = 0;
        #1;
        while (rvalid !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        if (rvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL rvalid_timeout: rvalid=%b expected 1", rvalid);
        end
        @(negedge clk);
        rready = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        int         t;
        idle(4);
        rst = 0;
        n_cmp++;
        if (bvalid !== 0 || rvalid !== 0 || irq_out !== 0 || rdata !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: bvalid=%b rvalid=%b irq=%b rdata=%h expected zeros",
                     bvalid, rvalid, irq_out, rdata);
        end
        rd(8'h14, 0);
        rd(8'h08, 0);

        wrs(8'h0C, 32'h3FF);
        wrs(8'h08, 32'h002);
        @(negedge clk) irq_src = 10'h002;
        @(negedge clk) irq_src = 10'h000;
        idle(3);
        rd(8'h04, 0);
        wrs(8'h04, 32'h002);
        idle(2);
        rd(8'h04, 1);

        wrs(8'h0C, 32'h0);
        wrs(8'h08, 32'h001);
        @(negedge clk) irq_src = 10'h001;
        idle(3);
        wrs(8'h04, 32'h001);
        idle(2);
        rd(8'h04, 0);
        @(negedge clk) irq_src = 10'h000;
        idle(2);
        rd(8'h04, 0);

        wrs(8'h0C, 32'h3FF);
        wr(8'h04, 32'h010, 4'hF, 0, 0, 1'b1, 10'h010);
        rd(8'h04, 0);
        @(negedge clk) irq_src = 10'h000;

        wr(8'h08, 32'h155, 4'hF, 5, 3, 1'b0, '0);
        rd(8'h08, 0);
        wrs(8'h40, 32'hFFFF_FFFF);
        rd(8'h40, 0);
        rd(8'h08, 2);

        wr(8'h08, 32'hFFFF_FFFF, 4'b0001, 0, 0, 1'b0, '0);
        rd(8'h08, 0);
        wrs(8'h10, 32'h200);
        rd(8'h04, 0);
        rd(8'h00, 0);

        // Abort a write while its response is pending
        @(negedge clk);
        awaddr = 8'h08; wdata = 32'h3; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        t = 0;
        #1;
        while (awready !== 1'b1 && t < 16) begin
            @(negedge clk); #1; t++;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0; rst = 1;
        #1;
        n_cmp++;
        if (bvalid !== 0 || irq_out !== 0) begin
            n_err++;
            $display("FAIL reset_abort: bvalid=%b irq=%b expected 0 0", bvalid, irq_out);
        end
        @(negedge clk) rst = 0;
        rd(8'h08, 0);
        rd(8'h0C, 0);

        for (int it = 0; it < 300; it++) begin
            case ($urandom % 4)
                0: begin
                    @(negedge clk) irq_src = N'($urandom);
                    idle($urandom_range(0, 3));
                end
                1: begin
                    a = 8'($urandom_range(0, 9) * 4) | 8'($urandom_range(0, 3));
                    wr(a, $urandom, 4'($urandom), $urandom_range(0, 2),
                       $urandom_range(0, 2), 1'($urandom), N'($urandom));
                end
                2: rd(8'($urandom_range(0, 9) * 4), $urandom_range(0, 2));
                default: begin
                    a = 8'($urandom_range(1, 4) * 4);
                    wr(a, $urandom, 4'hF, 0, 0, 1'($urandom), N'($urandom));
                    rd(8'h04, 0);
                end
            endcase
        end

        idle(5);
        n_cmp++;
        if (bq.size() != 0 || rq_data.size() != 0) begin
            n_err++;
            $display("FAIL drain: pending b=%0d r=%0d expected 0 0", bq.size(), rq_data.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
